ps2_scan_code_controller: RTL and testbench

//  Sequences the PS/2 byte receiver and turns its byte stream into key events.

---
 rtl/ps2_scan_code_controller_if.sv | 20 ++
 rtl/ps2_scan_code_controller.sv | 177 +++++++++++++++++
 tb/tb_ps2_scan_code_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_code_controller_if.sv
// Byte bus between the PS/2 data-in receiver (master) and the scan-code controller (slave).
// Handshake: received_data is valid only in the cycle where received_data_en=1. The
// strobe has no backpressure. wait_for_incoming_data is a level that arms the receiver.
interface ps2_scan_code_controller_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       wait_for_incoming_data;

  modport master (
    output received_data,
    output received_data_en,
    input  wait_for_incoming_data
  );

  modport slave (
    input  received_data,
    input  received_data_en,
    output wait_for_incoming_data
  );
endinterface

// File: rtl/ps2_scan_code_controller.sv
// Turns the PS/2 receiver byte stream into key events, assembling E0/F0 prefixes
// and keeping level "held" flags for space, up and down.
module ps2_scan_code_controller #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  ps2_scan_code_controller_if.slave       rx,
  output logic [7:0]                      key_code,
  output logic                            key_extended,
  output logic                            key_break,
  output logic                            key_valid,
  output logic                            space_held,
  output logic                            up_held,
  output logic                            down_held,
  output logic                            proto_err,
  output logic [2:0]                      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BASE    = 3'd1,
    S_EXT     = 3'd2,
    S_BRK     = 3'd3,
    S_EXT_BRK = 3'd4
  } state_t;

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] K_SPACE = 8'h29;
  localparam logic [7:0] K_UP    = 8'h75;
  localparam logic [7:0] K_DOWN  = 8'h72;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic                 wait_q, wait_d;
  logic [7:0]           key_code_q, key_code_d;
  logic                 key_ext_q, key_ext_d;
  logic                 key_brk_q, key_brk_d;
  logic                 key_valid_q, key_valid_d;
  logic                 space_q, space_d;
  logic                 up_q, up_d;
  logic                 down_q, down_d;
  logic                 err_q, err_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic       ev;
  logic       ev_ext;
  logic       ev_brk;
  logic       is_status;
  logic [7:0] byte_in;

  assign byte_in   = rx.received_data;
  assign is_status = (byte_in == 8'hFA) || (byte_in == 8'hAA) || (byte_in == 8'hEE) ||
                     (byte_in == 8'hFC) || (byte_in == 8'hFD) || (byte_in == 8'h00) ||
                     (byte_in == 8'hFF);

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_brk_d   = key_brk_q;
    key_valid_d = 1'b0;
    space_d     = space_q;
    up_d        = up_q;
    down_d      = down_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    ev          = 1'b0;
    ev_ext      = 1'b0;
    ev_brk      = 1'b0;

    if (!enable) begin
      // Disabling drops any partial code and forgets every held key.
      state_d = S_IDLE;
      space_d = 1'b0;
      up_d    = 1'b0;
      down_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BASE;
          cnt_d   = '0;
        end
        S_BASE: begin
          cnt_d = '0;
          if (rx.received_data_en) begin
            if (byte_in == B_EXT)      state_d = S_EXT;
            else if (byte_in == B_BRK) state_d = S_BRK;
            else if (!is_status)       ev = 1'b1;
          end
        end
        S_EXT, S_BRK, S_EXT_BRK: begin
          // A strobe on the expiry cycle is decoded; the timeout only fires without one.
          if (rx.received_data_en) begin
            cnt_d   = '0;
            state_d = S_BASE;
            if (state_q == S_EXT && byte_in == B_BRK) begin
              state_d = S_EXT_BRK;
            end else if (byte_in == B_EXT || byte_in == B_BRK) begin
              err_d = 1'b1;
            end else begin
              ev     = 1'b1;
              ev_ext = (state_q != S_BRK);
              ev_brk = (state_q != S_EXT);
            end
          end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = S_BASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (ev) begin
      key_code_d  = byte_in;
      key_ext_d   = ev_ext;
      key_brk_d   = ev_brk;
      key_valid_d = 1'b1;
      if (!ev_ext && byte_in == K_SPACE) space_d = !ev_brk;
      if (ev_ext && byte_in == K_UP)     up_d    = !ev_brk;
      if (ev_ext && byte_in == K_DOWN)   down_d  = !ev_brk;
    end

    wait_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_brk_q   <= 1'b0;
      key_valid_q <= 1'b0;
      space_q     <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_brk_q   <= key_brk_d;
      key_valid_q <= key_valid_d;
      space_q     <= space_d;
      up_q        <= up_d;
      down_q      <= down_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rx.wait_for_incoming_data = wait_q;
  assign key_code     = key_code_q;
  assign key_extended = key_ext_q;
  assign key_break    = key_brk_q;
  assign key_valid    = key_valid_q;
  assign space_held   = space_q;
  assign up_held      = up_q;
  assign down_held    = down_q;
  assign proto_err    = err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ps2_scan_code_controller.sv
// Directed bench for ps2_scan_code_controller: a vector table for byte sequences plus
// hand-written sequences for timeout, disable and asynchronous reset.
module tb_ps2_scan_code_controller;

  localparam int TO = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_BASE = 3'd1;
  localparam logic [2:0] ST_EXT  = 3'd2;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_break;
  logic       key_valid;
  logic       space_held;
  logic       up_held;
  logic       down_held;
  logic       proto_err;
  logic [2:0] state_dbg;

  int n_cmp;
  int n_err;

  ps2_scan_code_controller_if bus ();

  ps2_scan_code_controller #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rx           (bus.slave),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_break    (key_break),
    .key_valid    (key_valid),
    .space_held   (space_held),
    .up_held      (up_held),
    .down_held    (down_held),
    .proto_err    (proto_err),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       v;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       sp;
    logic       up;
    logic       dn;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one strobe; on return the outputs reflect the edge that sampled it.
  task automatic send_byte(input logic [7:0] b);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    tick();
    bus.received_data_en = 1'b0;
  endtask

  task automatic add(input logic [7:0] d, input logic v, input logic [7:0] c,
                     input logic e, input logic b, input logic sp, input logic up,
                     input logic dn, input logic er);
    vec_t r;
    r.data = d; r.v = v; r.code = c; r.ext = e; r.brk = b;
    r.sp = sp; r.up = up; r.dn = dn; r.err = er;
    tbl.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " key_valid"}, 32'(key_valid), 32'd0);
    check({tag, " key_code"}, 32'(key_code), 32'h00);
    check({tag, " ext/brk"}, 32'({key_extended, key_break}), 32'd0);
    check({tag, " held"}, 32'({space_held, up_held, down_held}), 32'd0);
    check({tag, " proto_err"}, 32'(proto_err), 32'd0);
    check({tag, " wait"}, 32'(bus.wait_for_incoming_data), 32'd0);
    check({tag, " state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    enable = 1'b0;
    bus.received_data = 8'h00;
    bus.received_data_en = 1'b0;

    //     data   v  code  e  b  sp up dn err
    add(8'h29, 1, 8'h29, 0, 0, 1, 0, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    add(8'h29, 1, 8'h29, 0, 1, 0, 0, 0, 0);
    add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(8'h75, 1, 8'h75, 1, 0, 0, 1, 0, 0);
    add(8'hE0, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0, 0, 1, 0, 0);
    add(8'h75, 1, 8'h75, 1, 1, 0, 0, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(8'hAA, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(8'hFA, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(8'h72, 1, 8'h72, 1, 0, 0, 0, 1, 0);
    add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    add(8'h72, 1, 8'h72, 1, 1, 0, 0, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(8'h75, 1, 8'h75, 0, 1, 0, 0, 0, 0);
    add(8'h1C, 1, 8'h1C, 0, 0, 0, 0, 0, 0);
    add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(8'hE0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    add(8'h29, 1, 8'h29, 0, 0, 1, 0, 0, 0);
    add(8'hF0, 0, 8'h00, 0, 0, 1, 0, 0, 0);
    add(8'h29, 1, 8'h29, 0, 1, 0, 0, 0, 0);

    // reset state
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check_all_zero("post_reset_disabled");

    enable = 1'b1;
    tick();
    check("arm state", 32'(state_dbg), 32'(ST_BASE));
    check("arm wait", 32'(bus.wait_for_incoming_data), 32'd1);

    // table-driven byte sequences
    for (int i = 0; i < tbl.size(); i++) begin
      send_byte(tbl[i].data);
      check($sformatf("v%0d key_valid", i), 32'(key_valid), 32'(tbl[i].v));
      check($sformatf("v%0d proto_err", i), 32'(proto_err), 32'(tbl[i].err));
      check($sformatf("v%0d held", i), 32'({space_held, up_held, down_held}),
            32'({tbl[i].sp, tbl[i].up, tbl[i].dn}));
      if (tbl[i].v)
        check($sformatf("v%0d code/ext/brk", i), 32'({key_code, key_extended, key_break}),
              32'({tbl[i].code, tbl[i].ext, tbl[i].brk}));
    end
    tick();
    check("valid drops", 32'(key_valid), 32'd0);

    // timeout after E0: silent for TO-1 edges, error on the TO-th
    send_byte(8'hE0);
    for (int k = 1; k < TO; k++) begin
      tick();
      check($sformatf("to wait %0d", k), 32'({proto_err, state_dbg}), 32'({1'b0, ST_EXT}));
    end
    tick();
    check("to err", 32'({proto_err, key_valid}), 32'b10);
    check("to state", 32'(state_dbg), 32'(ST_BASE));
    tick();
    check("to err drops", 32'(proto_err), 32'd0);
    send_byte(8'h72);
    check("after to", 32'({key_valid, key_code, key_extended, key_break, down_held}),
          32'({1'b1, 8'h72, 1'b0, 1'b0, 1'b0}));

    // strobe on the expiry cycle wins over the timeout
    send_byte(8'hE0);
    for (int k = 1; k < TO; k++) tick();
    send_byte(8'h75);
    check("expiry byte", 32'({key_valid, proto_err, key_code, key_extended, key_break}),
          32'({1'b1, 1'b0, 8'h75, 1'b1, 1'b0}));
    check("expiry up", 32'(up_held), 32'd1);
    tick();
    check("expiry no late err", 32'(proto_err), 32'd0);

    // disable while up is held
    enable = 1'b0;
    tick();
    check("dis wait", 32'(bus.wait_for_incoming_data), 32'd0);
    check("dis up", 32'(up_held), 32'd0);
    check("dis state", 32'(state_dbg), 32'(ST_IDLE));
    send_byte(8'h29);
    check("dis strobe", 32'({key_valid, proto_err, space_held}), 32'd0);
    send_byte(8'hE0);
    send_byte(8'h75);
    check("dis strobe2", 32'({key_valid, proto_err, up_held}), 32'd0);

    // asynchronous reset mid-sequence
    enable = 1'b1;
    tick();
    send_byte(8'hE0);
    check("pre rst state", 32'(state_dbg), 32'(ST_EXT));
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async rst");
    tick();
    reset = 1'b0;
    tick();
    check("rst rearm", 32'(state_dbg), 32'(ST_BASE));
    send_byte(8'h75);
    check("rst decode", 32'({key_valid, key_code, key_extended, key_break, up_held}),
          32'({1'b1, 8'h75, 1'b0, 1'b0, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
